data_memory: RTL and testbench

//  Byte-addressable 64-bit data memory for the CPU datapath MEM stage.

---
 rtl/data_memory.sv | 68 ++++++
 tb/tb_data_memory.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
//   Byte-addressable 64-bit data memory for the MEM stage of the CPU datapath.
//   Writes are synchronous doublewords. Reads are combinational doublewords.
//   Byte order is little-endian. Unaligned accesses are allowed, and the byte
//   address wraps at the top of the 2^MEM_AW-byte array.
//   Synchronous reset reloads mem[i] = i[7:0], so every read is predictable.
//
// Ports
//   clk        in   1       clock; all state changes on the rising edge
//   reset      in   1       synchronous, active-high; has priority over writes
//   Add        in   ADDR_W  byte address; only Add[MEM_AW-1:0] is used
//   MemWrite   in   1       write enable, sampled at posedge clk
//   MemRead    in   1       combinational read enable; ReadData is 0 when low
//   WriteData  in   DATA_W  doubleword to store
//   ReadData   out  DATA_W  doubleword read from Add (wrapped)
// ----------------------------------------------------------------------------
module data_memory #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Add,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned Depth    = 1 << MEM_AW;

    logic [7:0]        mem [Depth];
    logic [MEM_AW-1:0] effAddr;

    assign effAddr = Add[MEM_AW-1:0];

    // The upper address bits are intentionally ignored.
    logic unusedAddrBits;
    assign unusedAddrBits = ^Add[ADDR_W-1:MEM_AW];

    // The byte index is MEM_AW bits wide, so effAddr + k wraps modulo 2^MEM_AW
    // without any extra logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= i[7:0];
            end
        end else if (MemWrite) begin
            for (int k = 0; k < NumBytes; k++) begin
                mem[effAddr + MEM_AW'(k)] <= WriteData[8*k +: 8];
            end
        end
    end

    // The read is not gated by reset. It always reflects the current contents.
    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            for (int k = 0; k < NumBytes; k++) begin
                ReadData[8*k +: 8] = mem[effAddr + MEM_AW'(k)];
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] Add;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] WriteData;
    logic [63:0] ReadData;

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    data_memory dut (
        .clk       (clk),
        .reset     (reset),
        .Add       (Add),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .WriteData (WriteData),
        .ReadData  (ReadData)
    );

    // A one-edge write, driven from a negedge so that inputs are stable.
    task automatic doWrite(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        Add = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Add = '0; WriteData = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MemRead = 1'b1;
        Add = 64'haf; #1;
        totalCnt++;
        if (ReadData !== 64'hb6b5b4b3b2b1b0af)
            $display("FAIL reset_af: got %h expected %h", ReadData, 64'hb6b5b4b3b2b1b0af);
        else passCnt++;
        Add = 64'h0; #1;
        totalCnt++;
        if (ReadData !== 64'h0706050403020100)
            $display("FAIL reset_0: got %h expected %h", ReadData, 64'h0706050403020100);
        else passCnt++;
        Add = 64'hfffc; #1;
        totalCnt++;
        if (ReadData !== 64'h03020100fffefdfc)
            $display("FAIL reset_wrap: got %h expected %h", ReadData, 64'h03020100fffefdfc);
        else passCnt++;
    endtask

    task automatic test_write();
        doWrite(64'haaae, 64'hefa);
        MemRead = 1'b1;
        Add = 64'haaae; #1;
        totalCnt++;
        if (ReadData !== 64'h0000000000000efa)
            $display("FAIL write_aaae: got %h expected %h", ReadData, 64'h0000000000000efa);
        else passCnt++;
        Add = 64'haaad; #1;
        totalCnt++;
        if (ReadData !== 64'h00000000000efaad)
            $display("FAIL write_aaad: got %h expected %h", ReadData, 64'h00000000000efaad);
        else passCnt++;
        Add = 64'haaaf; #1;
        totalCnt++;
        if (ReadData !== 64'hb60000000000000e)
            $display("FAIL write_aaaf: got %h expected %h", ReadData, 64'hb60000000000000e);
        else passCnt++;
    endtask

    task automatic test_read_enable();
        MemRead = 1'b0;
        Add = 64'haf; #1;
        totalCnt++;
        if (ReadData !== 64'h0)
            $display("FAIL noread_af: got %h expected %h", ReadData, 64'h0);
        else passCnt++;
        Add = 64'haaae; #1;
        totalCnt++;
        if (ReadData !== 64'h0)
            $display("FAIL noread_aaae: got %h expected %h", ReadData, 64'h0);
        else passCnt++;
        MemRead = 1'b1;
        Add = 64'h1_0000_00af; #1;
        totalCnt++;
        if (ReadData !== 64'hb6b5b4b3b2b1b0af)
            $display("FAIL highbits: got %h expected %h", ReadData, 64'hb6b5b4b3b2b1b0af);
        else passCnt++;
        Add = 64'hffff_ffff_ffff_00af; #1;
        totalCnt++;
        if (ReadData !== 64'hb6b5b4b3b2b1b0af)
            $display("FAIL allhigh: got %h expected %h", ReadData, 64'hb6b5b4b3b2b1b0af);
        else passCnt++;
    endtask

    task automatic test_wrap();
        doWrite(64'hfffc, 64'h1122334455667788);
        MemRead = 1'b1;
        Add = 64'h0; #1;
        totalCnt++;
        if (ReadData !== 64'h0706050411223344)
            $display("FAIL wrap_0: got %h expected %h", ReadData, 64'h0706050411223344);
        else passCnt++;
        Add = 64'hfffc; #1;
        totalCnt++;
        if (ReadData !== 64'h1122334455667788)
            $display("FAIL wrap_fffc: got %h expected %h", ReadData, 64'h1122334455667788);
        else passCnt++;
        Add = 64'hfffe; #1;
        totalCnt++;
        if (ReadData !== 64'h0504112233445566)
            $display("FAIL wrap_fffe: got %h expected %h", ReadData, 64'h0504112233445566);
        else passCnt++;
    endtask

    task automatic test_collision();
        @(negedge clk);
        Add = 64'h40; WriteData = 64'hdead_beef; MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        totalCnt++;
        if (ReadData !== 64'h4746454443424140)
            $display("FAIL coll_before: got %h expected %h", ReadData, 64'h4746454443424140);
        else passCnt++;
        @(posedge clk);
        #1;
        totalCnt++;
        if (ReadData !== 64'h00000000deadbeef)
            $display("FAIL coll_after: got %h expected %h", ReadData, 64'h00000000deadbeef);
        else passCnt++;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        MemRead = 1'b0; MemWrite = 1'b1;
        Add = 64'h100; WriteData = 64'h1111111111111111;
        @(negedge clk);
        Add = 64'h104; WriteData = 64'h2222222222222222;
        @(negedge clk);
        MemWrite = 1'b0; MemRead = 1'b1;
        Add = 64'h100; #1;
        totalCnt++;
        if (ReadData !== 64'h2222222211111111)
            $display("FAIL b2b_100: got %h expected %h", ReadData, 64'h2222222211111111);
        else passCnt++;
        Add = 64'h104; #1;
        totalCnt++;
        if (ReadData !== 64'h2222222222222222)
            $display("FAIL b2b_104: got %h expected %h", ReadData, 64'h2222222222222222);
        else passCnt++;
        Add = 64'h108; #1;
        totalCnt++;
        if (ReadData !== 64'h0f0e0d0c22222222)
            $display("FAIL b2b_108: got %h expected %h", ReadData, 64'h0f0e0d0c22222222);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b1; MemRead = 1'b1;
        Add = 64'haaae; WriteData = 64'hffff;
        #1;
        // Reset does not force the read port.
        totalCnt++;
        if (ReadData !== 64'h0000000000000efa)
            $display("FAIL rst_read: got %h expected %h", ReadData, 64'h0000000000000efa);
        else passCnt++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MemWrite = 1'b0;
        #1;
        totalCnt++;
        if (ReadData !== 64'hb5b4b3b2b1b0afae)
            $display("FAIL rst_mid: got %h expected %h", ReadData, 64'hb5b4b3b2b1b0afae);
        else passCnt++;
        Add = 64'h40; #1;
        totalCnt++;
        if (ReadData !== 64'h4746454443424140)
            $display("FAIL rst_40: got %h expected %h", ReadData, 64'h4746454443424140);
        else passCnt++;
        Add = 64'h0; #1;
        totalCnt++;
        if (ReadData !== 64'h0706050403020100)
            $display("FAIL rst_0: got %h expected %h", ReadData, 64'h0706050403020100);
        else passCnt++;
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Add = '0; WriteData = '0;
        test_reset();
        test_write();
        test_read_enable();
        test_wrap();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
